cdec8_prog_loader: RTL and testbench

//  Program-memory and boot-sequencer stage directly upstream of the CDEC8 core.

---
 rtl/cdec8_prog_loader.sv | 148 ++++++++++++++
 tb/tb_cdec8_prog_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdec8_prog_loader.sv
// ----------------------------------------------------------------------------
// cdec8_prog_loader
//   Program memory and boot sequencer that sits directly upstream of the CDEC8
//   core. It holds a 256x8 RAM, which also serves as the core's data memory.
//   A byte stream loads a program image into the RAM while the core is held in
//   reset. The loader then releases the core to run the program. It stops the
//   core again on endseq or on a watchdog timeout, and the RAM stays readable
//   for result readback.
//
// Ports
//   clock, reset_N       system clock / asynchronous active-low reset
//   ld_data/valid/ready  program byte stream (header byte N, then N bytes;
//                        N=0 means 256)
//   cpu_reset_N          reset to the core, high only while running
//   cpu_adrs/wdata/wr_en core memory bus; cpu_rdata = mem[cpu_adrs]
//   endseq               core end-of-sequence flag
//   dbg_adrs/dbg_data    asynchronous RAM readback, valid in any state
//   busy, done, timeout  status (loading/running, finished, watchdog ended run)
//   run_cycles           cycles in last/current run, saturating
// ----------------------------------------------------------------------------
module cdec8_prog_loader #(
    parameter logic [15:0] WDOG_MAX = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset_N,
    input  logic [7:0]  ld_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    output logic        cpu_reset_N,
    input  logic [7:0]  cpu_adrs,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_wr_en,
    output logic [7:0]  cpu_rdata,
    input  logic        endseq,
    input  logic [7:0]  dbg_adrs,
    output logic [7:0]  dbg_data,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] run_cycles
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    // Index of the final image byte, so a 256-byte image is simply 8'hFF.
    logic [7:0]  r_last;
    logic [7:0]  w_last_nxt;
    logic        r_cpu_rst_n;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;
    logic        w_timeout_nxt;
    logic [15:0] r_run_cycles;
    logic [15:0] w_run_cycles_nxt;
    logic        w_ld_fire;
    logic        w_wdog_hit;

    logic [7:0]  r_mem [256];

    assign ld_ready   = (r_state != StRun);
    assign w_ld_fire  = ld_valid & ld_ready;
    assign w_wdog_hit = (WDOG_MAX != 16'd0) && (r_run_cycles == WDOG_MAX - 16'd1);

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_last_nxt       = r_last;
        w_timeout_nxt    = r_timeout;
        w_run_cycles_nxt = r_run_cycles;
        unique case (r_state)
            StIdle, StDone: begin
                if (w_ld_fire) begin
                    w_cnt_nxt     = 8'd0;
                    w_last_nxt    = ld_data - 8'd1;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = StLoad;
                end
            end
            StLoad: begin
                if (w_ld_fire) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt == r_last) begin
                        w_state_nxt      = StRun;
                        w_run_cycles_nxt = 16'd0;
                    end
                end
            end
            StRun: begin
                if (r_run_cycles != 16'hFFFF) begin
                    w_run_cycles_nxt = r_run_cycles + 16'd1;
                end
                // endseq has priority over a watchdog expiring in the same cycle.
                if (endseq) begin
                    w_state_nxt = StDone;
                end else if (w_wdog_hit) begin
                    w_state_nxt   = StDone;
                    w_timeout_nxt = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            r_state      <= StIdle;
            r_cnt        <= 8'd0;
            r_last       <= 8'd0;
            r_cpu_rst_n  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_run_cycles <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last       <= w_last_nxt;
            r_cpu_rst_n  <= (w_state_nxt == StRun);
            r_busy       <= (w_state_nxt == StLoad) || (w_state_nxt == StRun);
            r_done       <= (w_state_nxt == StDone);
            r_timeout    <= w_timeout_nxt;
            r_run_cycles <= w_run_cycles_nxt;
        end
    end

    // RAM has no reset. The loader and the core never write in the same state,
    // so state gating is the only arbitration needed.
    always_ff @(posedge clock) begin
        if (r_state == StLoad && w_ld_fire) begin
            r_mem[r_cnt] <= ld_data;
        end else if (r_state == StRun && cpu_wr_en) begin
            r_mem[cpu_adrs] <= cpu_wdata;
        end
    end

    assign cpu_rdata   = r_mem[cpu_adrs];
    assign dbg_data    = r_mem[dbg_adrs];
    assign cpu_reset_N = r_cpu_rst_n;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign run_cycles  = r_run_cycles;

endmodule

// File: tb/tb_cdec8_prog_loader.sv
module tb_cdec8_prog_loader;

    localparam logic [15:0] WDOG = 16'd20;

    logic        clock;
    logic        reset_N;
    logic [7:0]  ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic        cpu_reset_N;
    logic [7:0]  cpu_adrs;
    logic [7:0]  cpu_wdata;
    logic        cpu_wr_en;
    logic [7:0]  cpu_rdata;
    logic        endseq;
    logic [7:0]  dbg_adrs;
    logic [7:0]  dbg_data;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] run_cycles;

    cdec8_prog_loader #(.WDOG_MAX(WDOG)) dut (
        .clock(clock), .reset_N(reset_N), .ld_data(ld_data), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .cpu_reset_N(cpu_reset_N), .cpu_adrs(cpu_adrs),
        .cpu_wdata(cpu_wdata), .cpu_wr_en(cpu_wr_en), .cpu_rdata(cpu_rdata),
        .endseq(endseq), .dbg_adrs(dbg_adrs), .dbg_data(dbg_data), .busy(busy),
        .done(done), .timeout(timeout), .run_cycles(run_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: RAM image the bench believes is in memory.
    logic [7:0] m_mem [256];
    bit         m_vld [256];
    logic [7:0] prog_buf [256];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end in the low phase, right after a negedge.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        if (stall) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        ld_valid = 1'b1;
        ld_data  = b;
        // Loader-side core bus activity must not touch the RAM.
        cpu_wr_en = ($urandom_range(0, 3) == 0);
        cpu_adrs  = 8'($urandom);
        cpu_wdata = 8'($urandom);
        #1 check_eq("ld_ready_open", 32'(ld_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        ld_valid  = 1'b0;
        cpu_wr_en = 1'b0;
    endtask

    task automatic load_prog(input int len, input bit stall);
        send_byte(8'(len), stall);
        check_eq("hdr_busy", 32'(busy), 32'd1);
        check_eq("hdr_done_clr", 32'(done), 32'd0);
        check_eq("hdr_timeout_clr", 32'(timeout), 32'd0);
        check_eq("hdr_cpu_rst", 32'(cpu_reset_N), 32'd0);
        for (int i = 0; i < len; i++) begin
            send_byte(prog_buf[i], stall);
            m_mem[i] = prog_buf[i];
            m_vld[i] = 1'b1;
            if (i < len - 1) begin
                check_eq("load_cpu_rst_low", 32'(cpu_reset_N), 32'd0);
            end
        end
        check_eq("run_cpu_rst_high", 32'(cpu_reset_N), 32'd1);
        check_eq("run_ld_ready", 32'(ld_ready), 32'd0);
        check_eq("run_busy", 32'(busy), 32'd1);
    endtask

    // es = RUN cycle in which endseq is raised (0 = never).
    // dir_wr = single directed write 80<=3C in the first cycle, no random writes.
    task automatic run_prog(input int es, input bit dir_wr);
        int  k;
        int  exp_cycles;
        bit  exp_to;
        bit  wr;
        logic [7:0] hold_adr, hold_dat;
        exp_cycles = (es != 0 && es <= int'(WDOG)) ? es : int'(WDOG);
        exp_to     = !(es != 0 && es <= int'(WDOG));
        k = 0;
        while (k < exp_cycles) begin
            k++;
            cpu_adrs = 8'($urandom);
            if (dir_wr) begin
                wr = (k == 1);
                if (wr) cpu_adrs = 8'h80;
                cpu_wdata = 8'h3C;
            end else begin
                wr = ($urandom_range(0, 2) == 0);
                cpu_wdata = 8'($urandom);
            end
            cpu_wr_en = wr;
            endseq    = (k == es);
            // Bytes offered during RUN must be refused.
            ld_valid  = ($urandom_range(0, 3) == 0);
            ld_data   = 8'($urandom);
            #1;
            if (m_vld[cpu_adrs]) check_eq("cpu_rdata", 32'(cpu_rdata), 32'(m_mem[cpu_adrs]));
            check_eq("run_core_on", 32'(cpu_reset_N), 32'd1);
            check_eq("run_not_done", 32'(done), 32'd0);
            @(posedge clock);
            if (wr) begin
                m_mem[cpu_adrs] = cpu_wdata;
                m_vld[cpu_adrs] = 1'b1;
            end
            @(negedge clock);
            cpu_wr_en = 1'b0;
            endseq    = 1'b0;
            ld_valid  = 1'b0;
        end
        check_eq("end_done", 32'(done), 32'd1);
        check_eq("end_timeout", 32'(timeout), 32'(exp_to));
        check_eq("end_run_cycles", 32'(run_cycles), 32'(exp_cycles));
        check_eq("end_cpu_rst", 32'(cpu_reset_N), 32'd0);
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_ld_ready", 32'(ld_ready), 32'd1);
        // One DONE cycle with a core write attempt that must be ignored.
        hold_adr  = 8'($urandom);
        hold_dat  = 8'($urandom);
        cpu_adrs  = hold_adr;
        cpu_wdata = hold_dat;
        cpu_wr_en = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cpu_wr_en = 1'b0;
        check_eq("done_hold_cycles", 32'(run_cycles), 32'(exp_cycles));
        check_eq("done_hold_to", 32'(timeout), 32'(exp_to));
        check_eq("done_hold", 32'(done), 32'd1);
    endtask

    task automatic check_mem_all();
        for (int a = 0; a < 256; a++) begin
            if (m_vld[a]) begin
                dbg_adrs = 8'(a);
                #1 check_eq("dbg_mem", 32'(dbg_data), 32'(m_mem[a]));
            end
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
        check_eq({tag, "_cycles"}, 32'(run_cycles), 32'd0);
        check_eq({tag, "_cpu_rst"}, 32'(cpu_reset_N), 32'd0);
        check_eq({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
    endtask

    initial begin
        int len;
        reset_N = 1'b0; ld_data = 8'd0; ld_valid = 1'b0; cpu_adrs = 8'd0;
        cpu_wdata = 8'd0; cpu_wr_en = 1'b0; endseq = 1'b0; dbg_adrs = 8'd0;
        for (int a = 0; a < 256; a++) m_vld[a] = 1'b0;
        repeat (2) @(negedge clock);
        check_idle_outs("rst");
        reset_N = 1'b1;
        @(negedge clock);
        check_idle_outs("post_rst");

        // Header 3, A1 B2 C3, short run ended by endseq.
        prog_buf[0] = 8'hA1; prog_buf[1] = 8'hB2; prog_buf[2] = 8'hC3;
        load_prog(3, 1'b0);
        run_prog(5, 1'b0);
        check_mem_all();

        // 256-byte image; watchdog ends the run.
        for (int i = 0; i < 256; i++) prog_buf[i] = 8'(i) ^ 8'h5A;
        load_prog(256, 1'b0);
        dbg_adrs = 8'hFF;
        #1 check_eq("dbg_ff", 32'(dbg_data), 32'hA5);
        run_prog(0, 1'b0);
        check_mem_all();

        // Directed core write then endseq after 10 cycles.
        for (int i = 0; i < 4; i++) prog_buf[i] = 8'($urandom);
        load_prog(4, 1'b0);
        run_prog(10, 1'b1);
        dbg_adrs = 8'h80;
        #1 check_eq("mem80", 32'(dbg_data), 32'h3C);

        // endseq coincides with watchdog expiry: endseq wins.
        load_prog(2, 1'b0);
        run_prog(20, 1'b0);

        // Reset after 2 of 5 bytes.
        for (int i = 0; i < 5; i++) prog_buf[i] = 8'($urandom);
        send_byte(8'd5, 1'b0);
        for (int i = 0; i < 2; i++) begin
            send_byte(prog_buf[i], 1'b0);
            m_mem[i] = prog_buf[i];
            m_vld[i] = 1'b1;
        end
        #2 reset_N = 1'b0;
        #1 check_idle_outs("ld_rst");
        @(negedge clock);
        reset_N = 1'b1;
        check_mem_all();
        prog_buf[0] = 8'($urandom);
        load_prog(1, 1'b0);
        // Async reset mid-RUN drops cpu_reset_N immediately.
        repeat (3) @(negedge clock);
        check_eq("mid_run_core_on", 32'(cpu_reset_N), 32'd1);
        #2 reset_N = 1'b0;
        #1 check_idle_outs("run_rst");
        @(negedge clock);
        reset_N = 1'b1;
        @(negedge clock);

        // Timeout run, then DONE -> new 1-byte image 7E.
        load_prog(2, 1'b0);
        run_prog(0, 1'b0);
        prog_buf[0] = 8'h7E;
        load_prog(1, 1'b0);
        run_prog(3, 1'b0);
        dbg_adrs = 8'h00;
        #1 check_eq("mem0_7e", 32'(dbg_data), 32'h7E);

        // Randomized programs.
        for (int t = 0; t < 25; t++) begin
            len = ($urandom_range(0, 7) == 0) ? 256 : int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++) prog_buf[i] = 8'($urandom);
            load_prog(len, 1'b1);
            run_prog(int'($urandom_range(0, 25)), 1'b0);
            check_mem_all();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout_guard: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
